sha256_msg_sched: RTL and testbench
===================================

Name: sha256_msg_sched

Overview:
- Word-serial SHA-256 message schedule generator.
- Accepts one 512-bit block as 16 32-bit words (W0..W15, big-endian word order) over a valid/ready input stream.
- Emits the 64 expanded schedule words W0..W63 over a valid/ready output stream.
- The round datapath (Ch/Maj compression) consumes the output one word per round. This block is the producer end of that word interface.

Parameters:
- WordWidth, 32, schedule word width; fixed by SHA-256, must not be overridden.
- BlockWords, 16, words per input block.
- Rounds, 64, schedule words emitted per block.

Ports:
- clk_i  input  1  clock, all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- flush_i  input  1  synchronous abort of current block; discards state
- blk_valid_i  input  1  input word valid
- blk_ready_o  output  1  block accepts input word
- blk_word_i  input  32  message word, first beat = W0
- w_valid_o  output  1  schedule word valid
- w_ready_i  input  1  consumer accepts schedule word
- w_o  output  32  schedule word W_t
- w_idx_o  output  6  round index t of w_o
- w_last_o  output  1  high with t = 63

Behaviour:
- One clock; reset is synchronous and active-high (clk_i, rst_i).
- Storage: 16-entry x 32-bit window win[0..15]; win[0] is the oldest word.
- Counters: load counter lcnt (4 bit); round counter t (6 bit).
- States: LOAD and EMIT.
- Reset (rst_i = 1 at an edge):
  - state = LOAD, lcnt = 0, t = 0, window cleared to 0.
  - Resulting outputs: blk_ready_o = 1, w_valid_o = 0, w_o = 0, w_idx_o = 0, w_last_o = 0.
  - rst_i has priority over flush_i and all handshakes.
- LOAD:
  - blk_ready_o = 1, w_valid_o = 0.
  - On blk_valid_i & blk_ready_o: shift window down (win[i] <= win[i+1]); win[15] <= blk_word_i; lcnt++.
  - On the beat where lcnt = 15: go to EMIT, lcnt <= 0, t <= 0. After this beat win[0] = W0.
- EMIT:
  - blk_ready_o = 0, w_valid_o = 1.
  - w_o = win[0], w_idx_o = t, w_last_o = (t == 63).
  - w_o, w_idx_o and w_last_o come directly from registers; no combinational path from inputs to outputs.
- EMIT handshake (w_valid_o & w_ready_i):
  - Shift window down.
  - win[15] <= ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0], sum mod 2^32.
  - t++.
- Window content across rounds:
  - After each emit, win[0] = W(t+1) for all t.
  - Computed values for t >= 48 are never emitted; they are harmless.
- ssig0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x); ssig1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- Handshake at t = 63: return to LOAD, t <= 0. The next cycle blk_ready_o = 1 (one idle cycle between blocks; no overlap).
- Backpressure: while w_valid_o & !w_ready_i, w_o, w_idx_o and w_last_o stay stable. Window and t do not change.
- Input stall: blk_valid_i low in LOAD leaves everything unchanged. The input stream may contain gaps between beats.
- flush_i = 1 (no reset):
  - Next state = LOAD, lcnt = 0, t = 0.
  - Window contents are don't-care; they are fully overwritten by the next 16 loads.
  - Any handshake in the same cycle is ignored.
- No throughput requirement beyond 16 load beats + 64 emit beats per block (80 cycles minimum).

Decomposition:
- Package sha256_pkg:
  - Constants: WordWidth = 32, BlockWords = 16, Rounds = 64, rotate/shift amounts (7/18/3, 17/19/10).
  - State enum typedef sched_state_e {LOAD, EMIT}.
  - Typedef word_t = logic [31:0].
- One sub-module: sha256_ssig.
  - Parameterised on select Sel (0 = ssig0, 1 = ssig1).
  - Purely combinational, word_t in/out.
  - Instantiated twice.
  - Reused later by the compression datapath alongside the big-sigma variants.

Test Plan:
- FIPS "abc" block (0x61626380, fourteen 0x00000000, 0x00000018), w_ready_i tied 1:
  - W0..W15 echo the input.
  - W16 = 0x61626380, W17 = 0x000F0000, W18 = 0x7DA86405, W19 = 0x600003C6.
  - All 64 words match the software model.
  - w_last_o high only at w_idx_o = 63.
- Random w_ready_i (50%) on the "abc" block:
  - Word sequence is identical to the tied-ready run.
  - Outputs stay stable during every stall cycle.
  - Exactly 64 handshakes.
- Random gaps on blk_valid_i during load:
  - Schedule is identical to the gap-free run.
  - blk_ready_o drops exactly after the 16th accepted beat.
- Flush tests:
  - flush_i after 7 load beats, then a full new block: output matches the new block only.
  - flush_i at t = 30 returns to LOAD next cycle with w_valid_o = 0.
- rst_i asserted at t = 40 for 1 cycle:
  - Next cycle blk_ready_o = 1, w_valid_o = 0, w_o = 0, w_idx_o = 0.
  - A subsequent "abc" block produces the correct schedule.
- Two back-to-back random blocks with blk_valid_i held high:
  - Second block's words are not accepted before the t = 63 handshake.
  - Both schedules match the model.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and helpers for the message schedule and the
// round datapath.
package sha256_pkg;

   localparam int unsigned WordWidth  = 32;
   localparam int unsigned BlockWords = 16;
   localparam int unsigned Rounds     = 64;

   // Small-sigma rotate/shift amounts.
   localparam int unsigned Ssig0Rot1 = 7;
   localparam int unsigned Ssig0Rot2 = 18;
   localparam int unsigned Ssig0Shr  = 3;
   localparam int unsigned Ssig1Rot1 = 17;
   localparam int unsigned Ssig1Rot2 = 19;
   localparam int unsigned Ssig1Shr  = 10;

   typedef logic [WordWidth-1:0] word_t;

   typedef enum logic [0:0] {
      StLoad,
      StEmit
   } sched_state_e;

   // Rotate right by a constant amount in 1..WordWidth-1.
   function automatic word_t rotr(input word_t x, input int unsigned n);
      return (x >> n) | (x << (WordWidth - n));
   endfunction

endpackage

// File: rtl/sha256_ssig.sv
// SHA-256 small sigma function: Sel = 0 gives ssig0, Sel = 1 gives ssig1.
// Purely combinational; the compression datapath reuses it.
module sha256_ssig
   import sha256_pkg::*;
#(
   parameter int unsigned Sel = 0
) (
   input  logic [WordWidth-1:0] x_i,
   output logic [WordWidth-1:0] y_o
);

   localparam int unsigned Rot1 = (Sel == 0) ? Ssig0Rot1 : Ssig1Rot1;
   localparam int unsigned Rot2 = (Sel == 0) ? Ssig0Rot2 : Ssig1Rot2;
   localparam int unsigned Shr  = (Sel == 0) ? Ssig0Shr  : Ssig1Shr;

   // XOR of two rotations and one logical shift.
   always_comb begin
      y_o = rotr(x_i, Rot1) ^ rotr(x_i, Rot2) ^ (x_i >> Shr);
   end

endmodule

// File: rtl/sha256_msg_sched.sv
// Word-serial SHA-256 message schedule generator. Loads W0..W15 over a
// valid/ready stream, then emits W0..W63 one word per handshake.
module sha256_msg_sched
   import sha256_pkg::*;
#(
   // Fixed by SHA-256; the sigma units and window taps assume these values.
   parameter int unsigned WordWidth  = sha256_pkg::WordWidth,
   parameter int unsigned BlockWords = sha256_pkg::BlockWords,
   parameter int unsigned Rounds     = sha256_pkg::Rounds
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       blk_valid_i,
   output logic                       blk_ready_o,
   input  logic [WordWidth-1:0]       blk_word_i,
   output logic                       w_valid_o,
   input  logic                       w_ready_i,
   output logic [WordWidth-1:0]       w_o,
   output logic [$clog2(Rounds)-1:0]  w_idx_o,
   output logic                       w_last_o
);

   localparam int unsigned IdxW  = $clog2(Rounds);
   localparam int unsigned LcntW = $clog2(BlockWords);

   localparam logic [LcntW-1:0] LcntLast = LcntW'(BlockWords - 1);
   localparam logic [IdxW-1:0]  TLast    = IdxW'(Rounds - 1);
   localparam logic [IdxW-1:0]  TPenult  = IdxW'(Rounds - 2);

   sched_state_e                            state_q;
   // Window slot 0 is the oldest word and always the one being presented.
   logic [BlockWords-1:0][WordWidth-1:0]   win_q;
   logic [LcntW-1:0]                        lcnt_q;
   logic [IdxW-1:0]                         t_q;
   logic                                    last_q;

   logic [WordWidth-1:0] ssig0_w;
   logic [WordWidth-1:0] ssig1_w;
   logic [WordWidth-1:0] next_w;

   sha256_ssig #(
      .Sel (0)
   ) u_ssig0 (
      .x_i (win_q[1]),
      .y_o (ssig0_w)
   );

   sha256_ssig #(
      .Sel (1)
   ) u_ssig1 (
      .x_i (win_q[14]),
      .y_o (ssig1_w)
   );

   // Recurrence for the word entering the top of the window: W(t+16).
   always_comb begin
      next_w = ssig1_w + win_q[9] + ssig0_w + win_q[0];
   end

   // Load/emit control, window shift and counters; reset beats flush beats handshakes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StLoad;
         win_q   <= '0;
         lcnt_q  <= '0;
         t_q     <= '0;
         last_q  <= 1'b0;
      end else if (flush_i) begin
         // Window left as is; the next 16 loads overwrite every slot.
         state_q <= StLoad;
         lcnt_q  <= '0;
         t_q     <= '0;
         last_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StLoad: begin
               if (blk_valid_i) begin
                  win_q <= {blk_word_i, win_q[BlockWords-1:1]};
                  if (lcnt_q == LcntLast) begin
                     state_q <= StEmit;
                     lcnt_q  <= '0;
                     t_q     <= '0;
                     last_q  <= 1'b0;
                  end else begin
                     lcnt_q <= lcnt_q + 1'b1;
                  end
               end
            end
            StEmit: begin
               if (w_ready_i) begin
                  // Words computed past t = 47 are never emitted.
                  win_q <= {next_w, win_q[BlockWords-1:1]};
                  if (t_q == TLast) begin
                     state_q <= StLoad;
                     t_q     <= '0;
                     last_q  <= 1'b0;
                  end else begin
                     t_q    <= t_q + 1'b1;
                     last_q <= (t_q == TPenult);
                  end
               end
            end
            default: state_q <= StLoad;
         endcase
      end
   end

   // All outputs come straight from state registers.
   always_comb begin
      blk_ready_o = (state_q == StLoad);
      w_valid_o   = (state_q == StEmit);
      w_o         = win_q[0];
      w_idx_o     = t_q;
      w_last_o    = last_q;
   end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched with a queue-based scoreboard fed by a
// FIPS-style schedule model.
module tb_sha256_msg_sched;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        flush_i;
   logic        blk_valid_i;
   logic        blk_ready_o;
   logic [31:0] blk_word_i;
   logic        w_valid_o;
   logic        w_ready_i;
   logic [31:0] w_o;
   logic [5:0]  w_idx_o;
   logic        w_last_o;

   int unsigned vec_cnt = 0;
   int unsigned err_cnt = 0;

   logic [31:0] exp_q [$];
   logic [31:0] abc_blk [16];
   logic [31:0] rnd_a [16];
   logic [31:0] rnd_b [16];
   logic [31:0] rnd_c [16];
   logic [31:0] rnd_d [16];
   logic [31:0] abc_ref [4];

   always #5 clk = ~clk;

   sha256_msg_sched u_dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .blk_valid_i (blk_valid_i),
      .blk_ready_o (blk_ready_o),
      .blk_word_i  (blk_word_i),
      .w_valid_o   (w_valid_o),
      .w_ready_i   (w_ready_i),
      .w_o         (w_o),
      .w_idx_o     (w_idx_o),
      .w_last_o    (w_last_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   task automatic push_model(input logic [31:0] blk [16]);
      logic [31:0] w [64];
      for (int t = 0; t < 64; t++) begin
         if (t < 16) w[t] = blk[t];
         else        w[t] = sig1(w[t-2]) + w[t-7] + sig0(w[t-15]) + w[t-16];
         exp_q.push_back(w[t]);
      end
   endtask

   // Drive nbeats load beats with gap_pct percent idle cycles; a full block
   // also queues its expected schedule.
   task automatic load_block(input logic [31:0] blk [16], input int gap_pct, input int nbeats);
      int i = 0;
      int budget = 2000;
      bit v;
      if (nbeats == 16) push_model(blk);
      while (i < nbeats && budget > 0) begin
         v = ($urandom_range(99) >= gap_pct);
         blk_valid_i = v;
         blk_word_i  = blk[i];
         check("load_ready", blk_ready_o, 1);
         check("load_valid", w_valid_o, 0);
         @(negedge clk);
         if (v) i++;
         budget--;
      end
      blk_valid_i = 1'b0;
      check("load_beats", i, nbeats);
      if (nbeats == 16) check("ready_drop", blk_ready_o, 0);
   endtask

   // Consume stop_at schedule words with ready_pct percent ready; outputs are
   // checked on every valid cycle, so stalls are checked for stability too.
   task automatic drain(input int ready_pct, input int stop_at, input bit abc_spot);
      int idx = 0;
      int budget = 1000;
      bit r;
      logic [31:0] exp_w;
      while (idx < stop_at && budget > 0) begin
         r = ($urandom_range(99) < ready_pct);
         w_ready_i = r;
         exp_w = (exp_q.size() != 0) ? exp_q[0] : 32'hDEAD_BEEF;
         check("w_valid", w_valid_o, 1);
         check("blk_ready_emit", blk_ready_o, 0);
         check("w_word", w_o, exp_w);
         check("w_idx", w_idx_o, idx);
         check("w_last", w_last_o, (idx == 63));
         if (abc_spot && idx >= 16 && idx < 20) check("abc_spot", w_o, abc_ref[idx-16]);
         @(negedge clk);
         if (r) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            idx++;
         end
         budget--;
      end
      w_ready_i = 1'b0;
      check("drain_count", idx, stop_at);
   endtask

   task automatic check_idle();
      check("idle_ready", blk_ready_o, 1);
      check("idle_valid", w_valid_o, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i       = 1'b1;
      flush_i     = 1'b0;
      blk_valid_i = 1'b0;
      blk_word_i  = '0;
      w_ready_i   = 1'b0;

      for (int i = 0; i < 16; i++) begin
         abc_blk[i] = 32'h0;
         rnd_a[i]   = $urandom;
         rnd_b[i]   = $urandom;
         rnd_c[i]   = $urandom;
         rnd_d[i]   = $urandom;
      end
      abc_blk[0]  = 32'h6162_6380;
      abc_blk[15] = 32'h0000_0018;
      abc_ref[0]  = 32'h6162_6380;
      abc_ref[1]  = 32'h000F_0000;
      abc_ref[2]  = 32'h7DA8_6405;
      abc_ref[3]  = 32'h6000_03C6;

      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      check("rst_ready", blk_ready_o, 1);
      check("rst_valid", w_valid_o, 0);
      check("rst_w", w_o, 0);
      check("rst_idx", w_idx_o, 0);
      check("rst_last", w_last_o, 0);

      // "abc" block, ready tied high.
      load_block(abc_blk, 0, 16);
      drain(100, 64, 1'b1);
      check_idle();

      // "abc" block, random backpressure.
      load_block(abc_blk, 0, 16);
      drain(50, 64, 1'b1);
      check_idle();

      // Gapped input stream.
      load_block(rnd_a, 40, 16);
      drain(100, 64, 1'b0);
      check_idle();

      // Flush after 7 load beats, with a beat offered in the flush cycle.
      load_block(rnd_b, 0, 7);
      flush_i     = 1'b1;
      blk_valid_i = 1'b1;
      blk_word_i  = 32'hFFFF_FFFF;
      @(negedge clk);
      flush_i     = 1'b0;
      blk_valid_i = 1'b0;
      check("flush_load_ready", blk_ready_o, 1);
      check("flush_load_valid", w_valid_o, 0);
      load_block(rnd_c, 0, 16);
      drain(100, 64, 1'b0);
      check_idle();

      // Flush at t = 30 with a handshake offered in the same cycle.
      load_block(rnd_a, 0, 16);
      drain(100, 30, 1'b0);
      flush_i   = 1'b1;
      w_ready_i = 1'b1;
      @(negedge clk);
      flush_i   = 1'b0;
      w_ready_i = 1'b0;
      check("flush_emit_ready", blk_ready_o, 1);
      check("flush_emit_valid", w_valid_o, 0);
      check("flush_emit_idx", w_idx_o, 0);
      exp_q.delete();

      // Reset at t = 40, then a fresh "abc" block.
      load_block(rnd_b, 0, 16);
      drain(100, 40, 1'b0);
      rst_i     = 1'b1;
      w_ready_i = 1'b1;
      @(negedge clk);
      rst_i     = 1'b0;
      w_ready_i = 1'b0;
      check("rst40_ready", blk_ready_o, 1);
      check("rst40_valid", w_valid_o, 0);
      check("rst40_w", w_o, 0);
      check("rst40_idx", w_idx_o, 0);
      check("rst40_last", w_last_o, 0);
      exp_q.delete();
      load_block(abc_blk, 0, 16);
      drain(100, 64, 1'b1);
      check_idle();

      // Back-to-back blocks: next block's first word held valid during emit.
      load_block(rnd_c, 0, 16);
      blk_valid_i = 1'b1;
      blk_word_i  = rnd_d[0];
      drain(100, 64, 1'b0);
      load_block(rnd_d, 0, 16);
      drain(50, 64, 1'b0);
      check_idle();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
